// File: rtl/inst_fetch_if.sv
// Instruction ROM bus between the fetch stage (master) and the ROM (slave).
interface inst_fetch_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  modport master (output rom_ce, output rom_addr, input rom_inst);
  modport slave  (input rom_ce, input rom_addr, output rom_inst);
endinterface

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC, ROM request, IF/ID register, stall/branch/flush handling.
// Optional fetch counter enabled by defining FETCH_COUNT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         new_pc,
  input  logic                branch_flag,
  input  logic [31:0]         branch_target,
  inst_fetch_if.master        rom,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_inst,
  output logic                id_valid,
  output logic                fetch_err,
  output logic [31:0]         err_addr,
  output logic [31:0]         fetch_count
);

  localparam logic [1:0] StWait = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StErr  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  // PC, state and error next-state; reset is applied in the register block.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_err_d = fetch_err_q;
    err_addr_d  = err_addr_q;
    if (flush) begin
      if (new_pc[1:0] != 2'b00) begin
        state_d     = StErr;
        fetch_err_d = 1'b1;
        err_addr_d  = new_pc;
      end else begin
        state_d     = StRun;
        pc_d        = new_pc;
        fetch_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        StWait: state_d = StRun;
        StRun: begin
          if (!stall) begin
            if (branch_flag) begin
              if (branch_target[1:0] != 2'b00) begin
                state_d     = StErr;
                fetch_err_d = 1'b1;
                err_addr_d  = branch_target;
              end else begin
                pc_d = branch_target;
              end
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      if (state_q == StRun) begin
        id_pc_d    = pc_q;
        id_inst_d  = rom.rom_inst;
        id_valid_d = 1'b1;
      end else begin
        id_inst_d  = 32'h0;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWait;
      pc_q        <= RESET_PC;
      fetch_err_q <= 1'b0;
      err_addr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= 32'h0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_err_q <= fetch_err_d;
      err_addr_q  <= err_addr_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign rom.rom_ce   = (state_q == StRun);
  assign rom.rom_addr = pc_q;
  assign id_pc        = id_pc_q;
  assign id_inst      = id_inst_q;
  assign id_valid     = id_valid_q;
  assign fetch_err    = fetch_err_q;
  assign err_addr     = err_addr_q;

`ifdef FETCH_COUNT_EN
  logic        id_load;
  logic [31:0] count_q;

  assign id_load = !flush && !stall && (state_q == StRun);

  // Cleared by reset only; a flush kills IF/ID but not the running total.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'h0;
    end else if (id_load) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; ROM word k holds the value k.
module tb_inst_fetch;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        fetch_err;
  logic [31:0] err_addr;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_if rif ();

  assign rif.rom_inst = {2'b00, rif.rom_addr[31:2]};

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom           (rif.master),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .fetch_err     (fetch_err),
    .err_addr      (err_addr),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    check({tag, "_valid"}, {31'h0, id_valid}, 32'd1);
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_inst"}, id_inst, pc >> 2);
    check({tag, "_addr"}, rif.rom_addr, addr);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = '0;
    branch_flag = 1'b0; branch_target = '0;
    step();
    step();
    check("rst_ce", {31'h0, rif.rom_ce}, 32'd0);
    check("rst_addr", rif.rom_addr, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'd0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'd0);
    check("rst_erraddr", err_addr, 32'h0);
    check("rst_count", fetch_count, 32'h0);

    rst = 1'b0;
    check("wait_ce", {31'h0, rif.rom_ce}, 32'd0);
    step();
    check("run_ce", {31'h0, rif.rom_ce}, 32'd1);
    check("run_addr", rif.rom_addr, 32'h0);
    check("run_valid0", {31'h0, id_valid}, 32'd0);
    step(); check_fetch("f0", 32'h0, 32'h4);
    step(); check_fetch("f1", 32'h4, 32'h8);
    step(); check_fetch("f2", 32'h8, 32'hC);

    // Stall for three edges: everything frozen.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("stall", 32'h8, 32'hC);
    end
    stall = 1'b0;
    step(); check_fetch("resume", 32'hC, 32'h10);

    // Branch to 0x40; delay slot 0x10 still delivered.
    branch_flag = 1'b1; branch_target = 32'h40;
    step(); check_fetch("dslot", 32'h10, 32'h40);
    branch_flag = 1'b0;
    step(); check_fetch("btgt", 32'h40, 32'h44);

    // Flush beats stall and branch.
    flush = 1'b1; new_pc = 32'h100; stall = 1'b1;
    branch_flag = 1'b1; branch_target = 32'h200;
    step();
    check("flush_valid", {31'h0, id_valid}, 32'd0);
    check("flush_pc", id_pc, 32'h0);
    check("flush_inst", id_inst, 32'h0);
    check("flush_addr", rif.rom_addr, 32'h100);
    flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    step(); check_fetch("post_flush", 32'h100, 32'h104);

    // Misaligned branch target.
    branch_flag = 1'b1; branch_target = 32'h42;
    step();
    check_fetch("mis_dslot", 32'h104, 32'h104);
    check("mis_err", {31'h0, fetch_err}, 32'd1);
    check("mis_erraddr", err_addr, 32'h42);
    check("mis_ce", {31'h0, rif.rom_ce}, 32'd0);
    branch_flag = 1'b0;
    step();
    check("err_valid", {31'h0, id_valid}, 32'd0);
    check("err_inst", id_inst, 32'h0);
    check("err_addr_hold", rif.rom_addr, 32'h104);

    // Misaligned flush keeps ERR; aligned flush recovers.
    flush = 1'b1; new_pc = 32'h81;
    step();
    check("err2_err", {31'h0, fetch_err}, 32'd1);
    check("err2_erraddr", err_addr, 32'h81);
    check("err2_ce", {31'h0, rif.rom_ce}, 32'd0);
    new_pc = 32'h80;
    step();
    check("rec_err", {31'h0, fetch_err}, 32'd0);
    check("rec_ce", {31'h0, rif.rom_ce}, 32'd1);
    check("rec_addr", rif.rom_addr, 32'h80);
    check("rec_valid", {31'h0, id_valid}, 32'd0);
    flush = 1'b0;
    step(); check_fetch("rec_fetch", 32'h80, 32'h84);

    // PC+4 wraps at the top of the address space.
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_addr0", rif.rom_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    step(); check_fetch("wrap", 32'hFFFF_FFFC, 32'h0);
    check("wrap_err", {31'h0, fetch_err}, 32'd0);

    // Counter from a fresh reset: ten unstalled fetches.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check_fetch("cnt_last", 32'h24, 32'h28);
`ifdef FETCH_COUNT_EN
    check("count10", fetch_count, 32'd10);
`else
    check("count_tied", fetch_count, 32'h0);
`endif
    flush = 1'b1; new_pc = 32'h0;
    step();
    flush = 1'b0;
`ifdef FETCH_COUNT_EN
    check("count_flush", fetch_count, 32'd10);
`else
    check("count_flush", fetch_count, 32'h0);
`endif

    // Reset asserted during a stall is a full reset.
    stall = 1'b1; rst = 1'b1;
    step();
    check("rst2_count", fetch_count, 32'h0);
    check("rst2_ce", {31'h0, rif.rom_ce}, 32'd0);
    check("rst2_addr", rif.rom_addr, 32'h0);
    check("rst2_valid", {31'h0, id_valid}, 32'd0);
    check("rst2_pc", id_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
